// File: rtl/mopshub_selftest_pkg.sv
// Shared types and helpers for the MOPSHUB self-test sequencer.
// MOPSHUB_SELFTEST_CUSTOM_MSG_EN adds the custom-message phase states and phase code.
package mopshub_selftest_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TRIM,
    ST_WAIT_SIGNON,
    ST_SELECT,
    ST_RX_REQ,
    ST_RX_WAIT,
    ST_ENDWAIT,
    ST_GAP,
    ST_TX_REQ,
    ST_TX_WAIT,
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
    ST_CUST_REQ,
    ST_CUST_WAIT,
`endif
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_TRIM   = 3'd1;
  localparam logic [2:0] PH_SIGNON = 3'd2;
  localparam logic [2:0] PH_RX     = 3'd3;
  localparam logic [2:0] PH_TX     = 3'd4;
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
  localparam logic [2:0] PH_CUST   = 3'd5;
`endif
  localparam logic [2:0] PH_DONE   = 3'd7;

  // Highest requested bus index, limited to the last physical slot.
  function automatic int unsigned clamp_bus(input int unsigned req, input int unsigned n_slots);
    return (req > n_slots - 1) ? n_slots - 1 : req;
  endfunction

endpackage

// File: rtl/mopshub_phase_timer.sv
// Loadable down-counter shared by the phase timeout and the RX->TX gap count.
module mopshub_phase_timer #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_val,
  output logic                 expire
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TIMEOUT_W'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/mopshub_selftest_seq.sv
// MOPSHUB self-test sequencer: power-init, trim, sign-on, then per-bus RX/TX tests.
// MOPSHUB_SELFTEST_CUSTOM_MSG_EN adds a custom-message phase after TX on every bus.
module mopshub_selftest_seq
  import mopshub_selftest_pkg::*;
#(
  parameter int unsigned N_BUSES     = 16,
  parameter int unsigned BUS_ID_W    = 5,
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT_CYC = 40000,
  parameter int unsigned GAP_CYC     = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BUS_ID_W-1:0] n_buses,
  input  logic [N_BUSES-1:0]  bus_mask,
  input  logic                end_power_init,
  input  logic                sign_on,
  input  logic                rx_end,
  input  logic                tx_end,
  input  logic                rx_pass,
  input  logic                tx_pass,
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
  output logic                cust_start,
  input  logic                cust_end,
  input  logic                cust_pass,
`endif
  output logic                trim_en,
  output logic                rx_start,
  output logic                tx_start,
  output logic                endwait_all,
  output logic [BUS_ID_W-1:0] bus_id,
  output logic [2:0]          phase,
  output logic                busy,
  output logic                done,
  output logic [N_BUSES-1:0]  pass_mask,
  output logic [N_BUSES-1:0]  fail_mask,
  output logic                timeout_flag
);

  if (N_BUSES < 1 || N_BUSES > 32) begin : g_bad_n_buses
    $error("N_BUSES must be in 1..32");
  end
  if ((64'd1 << BUS_ID_W) < 64'(N_BUSES)) begin : g_bad_bus_id_w
    $error("BUS_ID_W too narrow for N_BUSES");
  end
  if (TIMEOUT_CYC < 1 || 64'(TIMEOUT_CYC) >= (64'd1 << TIMEOUT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYC does not fit in TIMEOUT_W");
  end
  if (GAP_CYC < 1 || 64'(GAP_CYC) >= (64'd1 << TIMEOUT_W)) begin : g_bad_gap
    $error("GAP_CYC does not fit in TIMEOUT_W");
  end

  state_e               state_q, state_d;
  logic [BUS_ID_W-1:0]  bus_id_q, bus_id_d, lim_q, lim_d;
  logic [N_BUSES-1:0]   mask_q, mask_d, pass_q, pass_d, fail_q, fail_d, bus_sel;
  logic                 ok_q, ok_d, to_q, to_d, done_q, done_d;
  logic                 bus_en, tmr_load, tmr_gap, tmr_expire;
  logic [TIMEOUT_W-1:0] tmr_val;

  assign bus_sel = N_BUSES'(1) << bus_id_q;
  assign bus_en  = |(mask_q & bus_sel);
  assign tmr_val = tmr_gap ? TIMEOUT_W'(GAP_CYC - 1) : TIMEOUT_W'(TIMEOUT_CYC - 1);

  mopshub_phase_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // ok_q accumulates the AND of every phase result for the current bus; a
  // matching end pulse takes priority over a timer expiry in the same cycle.
  always_comb begin
    state_d  = state_q;
    bus_id_d = bus_id_q;
    lim_d    = lim_q;
    mask_d   = mask_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ok_d     = ok_q;
    to_d     = to_q;
    done_d   = done_q;
    tmr_load = 1'b0;
    tmr_gap  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_TRIM;
        mask_d   = bus_mask;
        lim_d    = BUS_ID_W'(clamp_bus(32'(n_buses), N_BUSES));
        bus_id_d = '0;
        pass_d   = '0;
        fail_d   = '0;
        to_d     = 1'b0;
        done_d   = 1'b0;
      end
      ST_TRIM: if (end_power_init) state_d = ST_WAIT_SIGNON;
      ST_WAIT_SIGNON: if (sign_on) begin
        state_d  = ST_SELECT;
        bus_id_d = '0;
      end
      ST_SELECT: begin
        state_d = bus_en ? ST_RX_REQ : ST_NEXT;
        ok_d    = 1'b1;
      end
      ST_RX_REQ: begin
        tmr_load = 1'b1;
        state_d  = ST_RX_WAIT;
      end
      ST_RX_WAIT: if (rx_end) begin
        ok_d    = ok_q & rx_pass;
        state_d = ST_ENDWAIT;
      end else if (tmr_expire) begin
        ok_d    = 1'b0;
        to_d    = 1'b1;
        state_d = ST_ENDWAIT;
      end
      ST_ENDWAIT: begin
        tmr_load = 1'b1;
        tmr_gap  = 1'b1;
        state_d  = ST_GAP;
      end
      ST_GAP: if (tmr_expire) state_d = ST_TX_REQ;
      ST_TX_REQ: begin
        tmr_load = 1'b1;
        state_d  = ST_TX_WAIT;
      end
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
      ST_TX_WAIT: if (tx_end) begin
        ok_d    = ok_q & tx_pass;
        state_d = ST_CUST_REQ;
      end else if (tmr_expire) begin
        ok_d    = 1'b0;
        to_d    = 1'b1;
        state_d = ST_CUST_REQ;
      end
      ST_CUST_REQ: begin
        tmr_load = 1'b1;
        state_d  = ST_CUST_WAIT;
      end
      ST_CUST_WAIT: if (cust_end) begin
        ok_d    = ok_q & cust_pass;
        state_d = ST_NEXT;
      end else if (tmr_expire) begin
        ok_d    = 1'b0;
        to_d    = 1'b1;
        state_d = ST_NEXT;
      end
`else
      ST_TX_WAIT: if (tx_end) begin
        ok_d    = ok_q & tx_pass;
        state_d = ST_NEXT;
      end else if (tmr_expire) begin
        ok_d    = 1'b0;
        to_d    = 1'b1;
        state_d = ST_NEXT;
      end
`endif
      ST_NEXT: begin
        if (bus_en) begin
          pass_d = ok_q ? (pass_q | bus_sel) : pass_q;
          fail_d = ok_q ? fail_q : (fail_q | bus_sel);
        end
        if (bus_id_q == lim_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_SELECT;
          bus_id_d = bus_id_q + BUS_ID_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bus_id_q <= '0;
      lim_q    <= '0;
      mask_q   <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      ok_q     <= 1'b0;
      to_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus_id_q <= bus_id_d;
      lim_q    <= lim_d;
      mask_q   <= mask_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ok_q     <= ok_d;
      to_q     <= to_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_IDLE:        phase = PH_IDLE;
      ST_TRIM:        phase = PH_TRIM;
      ST_WAIT_SIGNON: phase = PH_SIGNON;
      ST_TX_REQ,
      ST_TX_WAIT:     phase = PH_TX;
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
      ST_CUST_REQ,
      ST_CUST_WAIT:   phase = PH_CUST;
`endif
      ST_DONE:        phase = PH_DONE;
      default:        phase = PH_RX;
    endcase
  end

  assign trim_en      = (state_q == ST_TRIM);
  assign rx_start     = (state_q == ST_RX_REQ);
  assign tx_start     = (state_q == ST_TX_REQ);
  assign endwait_all  = (state_q == ST_ENDWAIT);
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
  assign cust_start   = (state_q == ST_CUST_REQ);
`endif
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = done_q;
  assign bus_id       = bus_id_q;
  assign pass_mask    = pass_q;
  assign fail_mask    = fail_q;
  assign timeout_flag = to_q;

endmodule

// File: tb/tb_mopshub_selftest_seq.sv
// Scoreboard bench for mopshub_selftest_seq; define MOPSHUB_SELFTEST_CUSTOM_MSG_EN to cover the custom phase.
module tb_mopshub_selftest_seq;

  localparam int TIMEOUT_CYC = 100;
  localparam int GAP_CYC     = 4;
  localparam int EV_RX = 0, EV_TX = 1, EV_CU = 2, EV_DONE = 3;

  typedef struct {
    int          kind;
    int          bus;
    logic [15:0] pm;
    logic [15:0] fm;
    logic        to;
    int          ew;
  } ev_t;

  logic        clk, rst, start, end_power_init, sign_on;
  logic [4:0]  n_buses;
  logic [15:0] bus_mask;
  logic        rx_end, tx_end, rx_pass, tx_pass;
  logic        rsp_rx_end, rsp_tx_end, stray_end;
  logic        trim_en, rx_start, tx_start, endwait_all, busy, done, timeout_flag;
  logic [4:0]  bus_id;
  logic [2:0]  phase;
  logic [15:0] pass_mask, fail_mask;
  logic        cust_req;
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
  logic        cust_start, cust_end, cust_pass;
  assign cust_req = cust_start;
`else
  assign cust_req = 1'b0;
`endif

  assign rx_end = rsp_rx_end | stray_end;
  assign tx_end = rsp_tx_end | stray_end;

  int   rx_dly[16], tx_dly[16], cu_dly[16];
  logic rx_ok[16], tx_ok[16], cu_ok[16];
  ev_t  sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, last_ew = 0, ew_cnt = 0;

  mopshub_selftest_seq #(
    .N_BUSES(16), .BUS_ID_W(5), .TIMEOUT_W(16),
    .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_buses(n_buses), .bus_mask(bus_mask),
    .end_power_init(end_power_init), .sign_on(sign_on),
    .rx_end(rx_end), .tx_end(tx_end), .rx_pass(rx_pass), .tx_pass(tx_pass),
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
    .cust_start(cust_start), .cust_end(cust_end), .cust_pass(cust_pass),
`endif
    .trim_en(trim_en), .rx_start(rx_start), .tx_start(tx_start), .endwait_all(endwait_all),
    .bus_id(bus_id), .phase(phase), .busy(busy), .done(done),
    .pass_mask(pass_mask), .fail_mask(fail_mask), .timeout_flag(timeout_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by 50000 cycles, required run completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input int bus, input logic [15:0] pm = '0,
                      input logic [15:0] fm = '0, input logic to = 1'b0, input int ew = 0);
    ev_t e;
    e.kind = kind; e.bus = bus; e.pm = pm; e.fm = fm; e.to = to; e.ew = ew;
    sb.push_back(e);
  endtask

  task automatic defaults();
    for (int i = 0; i < 16; i++) begin
      rx_dly[i] = 50; tx_dly[i] = 50; cu_dly[i] = 50;
      rx_ok[i] = 1'b1; tx_ok[i] = 1'b1; cu_ok[i] = 1'b1;
    end
  endtask

  task automatic zero_outputs(input string pfx);
    check({pfx, "_ctrl"}, {25'd0, busy, done, trim_en, rx_start, tx_start, endwait_all, timeout_flag}, 0);
    check({pfx, "_bus_id"}, {27'd0, bus_id}, 0);
    check({pfx, "_phase"}, {29'd0, phase}, 0);
    check({pfx, "_pass_mask"}, {16'd0, pass_mask}, 0);
    check({pfx, "_fail_mask"}, {16'd0, fail_mask}, 0);
  endtask

  // Launch a run; a second start and stray end pulses land in TRIM and must be ignored.
  task automatic kick(input logic [15:0] mask, input logic [4:0] n);
    @(negedge clk); bus_mask = mask; n_buses = n; start = 1'b1;
    @(negedge clk); bus_mask = '0; n_buses = '0; stray_end = 1'b1;
    check("start_trim_en", {31'd0, trim_en}, 1);
    check("start_busy", {31'd0, busy}, 1);
    @(negedge clk); start = 1'b0; stray_end = 1'b0;
    repeat (2) @(negedge clk);
    end_power_init = 1'b1;
    @(negedge clk); end_power_init = 1'b0;
    check("signon_phase", {29'd0, phase}, 2);
    repeat (2) @(negedge clk);
    sign_on = 1'b1;
    @(negedge clk); sign_on = 1'b0;
  endtask

  task automatic push_bus(input int b);
    push(EV_RX, b);
    push(EV_TX, b);
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
    push(EV_CU, b);
`endif
  endtask

  task automatic run(input logic [15:0] mask, input logic [4:0] n, input int last,
                     input logic [15:0] pm, input logic [15:0] fm, input logic to, input int ew);
    for (int b = 0; b <= last; b++) if (mask[b[3:0]]) push_bus(b);
    push(EV_DONE, last, pm, fm, to, ew);
    kick(mask, n);
    for (int i = 0; i < 6000 && !done; i++) @(negedge clk);
    check("done_within_budget", {31'd0, done}, 1);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  // Responder: answers each request after the per-bus delay (0 = never answers).
  task automatic respond(input int kind);
    int b, d;
    logic ok;
    b  = int'(bus_id) & 15;
    d  = (kind == EV_RX) ? rx_dly[b] : (kind == EV_TX) ? tx_dly[b] : cu_dly[b];
    ok = (kind == EV_RX) ? rx_ok[b] : (kind == EV_TX) ? tx_ok[b] : cu_ok[b];
    if (d == 0) begin
      @(negedge clk);
    end else begin
      repeat (d) @(negedge clk);
      case (kind)
        EV_RX: begin rsp_rx_end = 1'b1; rx_pass = ok; end
        EV_TX: begin rsp_tx_end = 1'b1; tx_pass = ok; end
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
        default: begin cust_end = 1'b1; cust_pass = ok; end
`else
        default: ;
`endif
      endcase
      @(negedge clk);
      rsp_rx_end = 1'b0; rsp_tx_end = 1'b0; rx_pass = 1'b0; tx_pass = 1'b0;
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
      cust_end = 1'b0; cust_pass = 1'b0;
`endif
    end
  endtask

  initial begin
    rsp_rx_end = 1'b0; rsp_tx_end = 1'b0; rx_pass = 1'b0; tx_pass = 1'b0;
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
    cust_end = 1'b0; cust_pass = 1'b0;
`endif
    @(negedge clk);
    forever begin
      if (!rst && rx_start)      respond(EV_RX);
      else if (!rst && tx_start) respond(EV_TX);
      else if (!rst && cust_req) respond(EV_CU);
      else @(negedge clk);
    end
  end

  // Monitor: pops the expected event whenever the DUT issues a request or finishes.
  initial begin
    ev_t  e;
    int   k;
    logic done_d, busy_d;
    done_d = 1'b0; busy_d = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        done_d = 1'b0; busy_d = 1'b0;
      end else begin
        if (busy && !busy_d) ew_cnt = 0;
        if (rx_start || tx_start || cust_req) begin
          k = rx_start ? EV_RX : (tx_start ? EV_TX : EV_CU);
          check("req_expected", {31'd0, sb.size() != 0}, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("req_kind", k, e.kind);
            check("req_bus_id", {27'd0, bus_id}, e.bus);
            check("req_phase", {29'd0, phase}, (k == EV_RX) ? 3 : (k == EV_TX) ? 4 : 5);
          end
          if (tx_start) check("rx_to_tx_gap", cyc - last_ew, GAP_CYC + 1);
        end
        if (endwait_all) begin
          ew_cnt++;
          last_ew = cyc;
        end
        if (done && !done_d) begin
          check("done_expected", {31'd0, sb.size() != 0}, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("done_kind", EV_DONE, e.kind);
            check("done_pass_mask", {16'd0, pass_mask}, {16'd0, e.pm});
            check("done_fail_mask", {16'd0, fail_mask}, {16'd0, e.fm});
            check("done_timeout_flag", {31'd0, timeout_flag}, {31'd0, e.to});
            check("done_endwait_count", ew_cnt, e.ew);
            check("done_last_bus_id", {27'd0, bus_id}, e.bus);
            check("done_busy", {31'd0, busy}, 0);
            check("done_phase", {29'd0, phase}, 7);
          end
        end
        done_d = done;
        busy_d = busy;
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; end_power_init = 1'b0; sign_on = 1'b0; stray_end = 1'b0;
    n_buses = '0; bus_mask = '0;
    defaults();
    repeat (3) @(negedge clk);
    zero_outputs("reset");
    rst = 1'b0;

    defaults(); run(16'hFFFF, 5'd15, 15, 16'hFFFF, 16'h0000, 1'b0, 16);
    defaults(); run(16'h0005, 5'd3, 3, 16'h0005, 16'h0000, 1'b0, 2);
    defaults(); tx_dly[1] = 0;
    run(16'h0007, 5'd2, 2, 16'h0005, 16'h0002, 1'b1, 3);
    defaults(); rx_ok[1] = 1'b0; tx_ok[3] = 1'b0;
    run(16'h000F, 5'd3, 3, 16'h0005, 16'h000A, 1'b0, 4);
    defaults(); rx_dly[0] = TIMEOUT_CYC;
    run(16'h0001, 5'd0, 0, 16'h0001, 16'h0000, 1'b0, 1);
    defaults(); rx_dly[1] = TIMEOUT_CYC + 1;
    run(16'h0002, 5'd1, 1, 16'h0000, 16'h0002, 1'b1, 1);
    defaults(); run(16'h0000, 5'd15, 15, 16'h0000, 16'h0000, 1'b0, 0);
    defaults(); run(16'h8001, 5'd31, 15, 16'h8001, 16'h0000, 1'b0, 2);
`ifdef MOPSHUB_SELFTEST_CUSTOM_MSG_EN
    defaults(); cu_ok[0] = 1'b0;
    run(16'h0001, 5'd0, 0, 16'h0000, 16'h0001, 1'b0, 1);
`endif

    // Abort: reset while bus 5 waits for a TX answer that never comes.
    defaults(); tx_dly[5] = 0;
    for (int b = 0; b < 5; b++) push_bus(b);
    push(EV_RX, 5);
    push(EV_TX, 5);
    kick(16'hFFFF, 5'd15);
    for (int i = 0; i < 3000 && !(tx_start && bus_id == 5'd5); i++) @(negedge clk);
    check("abort_reach_bus5_tx", {26'd0, tx_start, bus_id}, {26'd0, 1'b1, 5'd5});
    repeat (3) @(negedge clk);
    check("abort_in_tx_wait", {29'd0, phase}, 4);
    check("abort_pre_pass_mask", {16'd0, pass_mask}, 32'h001F);
    rst = 1'b1;
    @(negedge clk);
    zero_outputs("abort");
    rst = 1'b0;
    @(negedge clk);
    check("abort_sb_drained", sb.size(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
